// File: rtl/cpu_pkg.sv
// Shared definitions for the LDM/STM block-transfer sequencer.
package cpu_pkg;

  localparam logic [3:0] REG_PC     = 4'd15;
  localparam int         WORD_BYTES = 4;
  localparam int         REG_COUNT  = 16;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    WB,
    DONE
  } seq_state_e;

  // Addressing mode as {P, U}
  typedef enum logic [1:0] {
    MODE_DA = 2'b00,
    MODE_IA = 2'b01,
    MODE_DB = 2'b10,
    MODE_IB = 2'b11
  } addr_mode_e;

endpackage

// File: rtl/ldm_stm_seq_if.sv
// Register-bank and memory-port bundle driven by the LDM/STM sequencer.
// LDM_STM_ABORT_EN adds the mem_abort response line.
interface ldm_stm_seq_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [3:0]        rb_read_select;
  logic              rb_read_en;
  logic [DATA_W-1:0] rb_read_data;
  logic [3:0]        rb_write_select;
  logic              rb_write_en;
  logic [DATA_W-1:0] rb_write_data;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
`ifdef LDM_STM_ABORT_EN
  logic              mem_abort;

  modport master (
    output rb_read_select, rb_read_en, rb_write_select, rb_write_en, rb_write_data,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  rb_read_data, mem_ack, mem_rdata, mem_abort
  );

  modport slave (
    input  rb_read_select, rb_read_en, rb_write_select, rb_write_en, rb_write_data,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output rb_read_data, mem_ack, mem_rdata, mem_abort
  );
`else
  modport master (
    output rb_read_select, rb_read_en, rb_write_select, rb_write_en, rb_write_data,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  rb_read_data, mem_ack, mem_rdata
  );

  modport slave (
    input  rb_read_select, rb_read_en, rb_write_select, rb_write_en, rb_write_data,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output rb_read_data, mem_ack, mem_rdata
  );
`endif
endinterface

// File: rtl/lowest_set_bit.sv
// Combinational priority encoder: index of the lowest set bit of a register list.
module lowest_set_bit
  import cpu_pkg::*;
(
  input  logic [REG_COUNT-1:0] bits,
  output logic [3:0]           index,
  output logic                 valid
);

  // Scanning from the top lets the lowest set bit win the last assignment
  always_comb begin
    index = '0;
    valid = 1'b0;
    for (int i = REG_COUNT - 1; i >= 0; i--) begin
      if (bits[i]) begin
        index = 4'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ldm_stm_seq.sv
// LDM/STM block-transfer sequencer: walks the register list lowest first, one word per beat.
// LDM_STM_ABORT_EN adds mem_abort handling and the aborted status output.
module ldm_stm_seq
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_load,
  input  logic [15:0]       reg_list,
  input  logic [3:0]        base_reg,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              pre_index,
  input  logic              up,
  input  logic              writeback,
  output logic              busy,
  output logic              done,
`ifdef LDM_STM_ABORT_EN
  output logic              aborted,
`endif
  ldm_stm_seq_if.master     bus
);

  seq_state_e           state, next_state;
  logic [REG_COUNT-1:0] remaining, remaining_next;
  logic [ADDR_W-1:0]    addr, final_base, base_word, span, start_addr;
  logic                 is_load_q, do_wb_q;
  logic [3:0]           base_reg_q;
  logic [4:0]           n;
  logic [3:0]           cur;
  logic                 cur_valid, last_beat, abort_beat;
  addr_mode_e           mode;

  lowest_set_bit u_lsb (
    .bits  (remaining),
    .index (cur),
    .valid (cur_valid)
  );

`ifdef LDM_STM_ABORT_EN
  logic aborted_q;

  assign abort_beat = bus.mem_abort;
  assign aborted    = (state == DONE) && aborted_q;

  always_ff @(posedge clk) begin
    if (reset)
      aborted_q <= 1'b0;
    else if (state == IDLE && start)
      aborted_q <= 1'b0;
    else if (state == XFER && bus.mem_abort)
      aborted_q <= 1'b1;
  end
`else
  assign abort_beat = 1'b0;
`endif

  // Command decode: the transferred block is always walked upwards from its lowest word
  always_comb begin
    n         = 5'($countones(reg_list));
    base_word = base_addr & ~ADDR_W'(3);
    span      = ADDR_W'(n) * ADDR_W'(WORD_BYTES);
    mode      = addr_mode_e'({pre_index, up});
    case (mode)
      MODE_IA: start_addr = base_word;
      MODE_IB: start_addr = base_word + ADDR_W'(WORD_BYTES);
      MODE_DA: start_addr = base_word - span + ADDR_W'(WORD_BYTES);
      default: start_addr = base_word - span;
    endcase
    remaining_next = remaining & ~(REG_COUNT'(1) << cur);
    last_beat      = (remaining_next == '0);
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  // Writeback is suppressed up front when a load overwrites the base register itself
  always_ff @(posedge clk) begin
    if (reset) begin
      remaining  <= '0;
      addr       <= '0;
      final_base <= '0;
      is_load_q  <= 1'b0;
      do_wb_q    <= 1'b0;
      base_reg_q <= '0;
    end else if (state == IDLE && start) begin
      remaining  <= reg_list;
      addr       <= start_addr;
      final_base <= up ? base_word + span : base_word - span;
      is_load_q  <= is_load;
      do_wb_q    <= writeback && !(is_load && reg_list[base_reg]);
      base_reg_q <= base_reg;
    end else if (state == XFER && bus.mem_ack && !abort_beat) begin
      remaining  <= remaining_next;
      addr       <= addr + ADDR_W'(WORD_BYTES);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = (n == 5'd0) ? DONE : XFER;
      XFER: begin
        if (!cur_valid || abort_beat)
          next_state = DONE;
        else if (bus.mem_ack && last_beat)
          next_state = do_wb_q ? WB : DONE;
      end
      WB:      next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Store data flows straight from the bank B bus; load data straight into the write port
  always_comb begin
    busy                = 1'b0;
    done                = 1'b0;
    bus.rb_read_select  = '0;
    bus.rb_read_en      = 1'b0;
    bus.rb_write_select = '0;
    bus.rb_write_en     = 1'b0;
    bus.rb_write_data   = '0;
    bus.mem_req         = 1'b0;
    bus.mem_we          = 1'b0;
    bus.mem_addr        = '0;
    bus.mem_wdata       = '0;
    case (state)
      XFER: begin
        busy         = 1'b1;
        bus.mem_req  = 1'b1;
        bus.mem_addr = addr & ~ADDR_W'(3);
        bus.mem_we   = !is_load_q;
        if (!is_load_q) begin
          bus.rb_read_en     = 1'b1;
          bus.rb_read_select = cur;
          bus.mem_wdata      = bus.rb_read_data;
        end else if (bus.mem_ack && !abort_beat) begin
          bus.rb_write_en     = 1'b1;
          bus.rb_write_select = cur;
          bus.rb_write_data   = bus.mem_rdata;
        end
      end
      WB: begin
        busy                = 1'b1;
        bus.rb_write_en     = 1'b1;
        bus.rb_write_select = base_reg_q;
        bus.rb_write_data   = DATA_W'(final_base);
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/ldm_stm_seq.md
Name: ldm_stm_seq

Overview:
- Multi-cycle block-transfer sequencer for LDM/STM.
- Walks a 16-bit register list lowest register first and steps the memory address by 4 per transfer.
- Side A drives the register bank's read-B port (stores) and write port (loads).
- Side B drives a single req/ack memory port.
- Sits between the instruction decoder and the register bank / memory interface; the datapath stalls while busy.

Parameters:
- ADDR_W, 32, memory address width.
- DATA_W, 32, register and memory data width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle command strobe; accepted only when busy=0
- is_load  in  1  1=LDM, 0=STM
- reg_list  in  16  bit i set means Ri is transferred
- base_reg  in  4  index of base register
- base_addr  in  ADDR_W  current value of the base register
- pre_index  in  1  P bit: 1=before, 0=after
- up  in  1  U bit: 1=increment, 0=decrement
- writeback  in  1  W bit: update base register at end
- busy  out  1  high while state != IDLE
- done  out  1  one-cycle completion pulse
- rb_read_select  out  4  register to read (store data)
- rb_read_en  out  1  enables the bank's tri-state B bus
- rb_read_data  in  DATA_W  bank B bus
- rb_write_select  out  4  register to write
- rb_write_en  out  1  bank write strobe
- rb_write_data  out  DATA_W  bank write data
- mem_req  out  1  transfer request, held until ack
- mem_we  out  1  1=store
- mem_addr  out  ADDR_W  word address (bits[1:0] forced 0)
- mem_wdata  out  DATA_W  store data
- mem_ack  in  1  transfer complete this cycle
- mem_rdata  in  DATA_W  load data, valid with mem_ack

Behaviour:
- Reset: state=IDLE; every output 0, including busy, done, mem_req, rb_write_en and rb_read_en.
- States: IDLE, XFER, WB, DONE.
- IDLE:
  - start latches all command inputs.
  - n = popcount(reg_list).
  - Start address, with base = base_addr & ~3:
    - IA (P=0,U=1): base
    - IB (P=1,U=1): base+4
    - DA (P=0,U=0): base-4n+4
    - DB (P=1,U=0): base-4n
  - Final base: U ? base+4n : base-4n.
  - If n=0: go to DONE (no transfers, no writeback). Otherwise go to XFER.
  - start while busy is ignored.
- XFER:
  - mem_req=1, mem_addr=current address, cur = lowest remaining set bit.
  - Store: rb_read_en=1, rb_read_select=cur, mem_we=1, mem_wdata=rb_read_data (combinational).
  - Load: mem_we=0.
  - On mem_ack:
    - Load: rb_write_en=1, rb_write_select=cur, rb_write_data=mem_rdata, all in the same cycle.
    - Clear cur in the remaining mask; address += 4.
  - Back-to-back: mem_req stays high into the next cycle, with the next register and address.
  - Last ack: go to WB if writeback && !(is_load && reg_list[base_reg]); otherwise go to DONE.
  - Registers always transfer in ascending index order at ascending addresses, independent of U.
- WB: one cycle; rb_write_en=1, rb_write_select=base_reg, rb_write_data=final base; then DONE.
- DONE: done=1 and busy=1 for one cycle; then IDLE.
- Load with base in list, W=1: the loaded value wins and no WB cycle occurs.
- STM including base_reg: stores the original base value (writeback happens after all stores).
- LDM including R15: written through the normal write port. The bank gives write_en priority over the PC incrementer, so no special path exists here.
- Address arithmetic wraps modulo 2^ADDR_W.
- Reset mid-operation: immediate return to IDLE, mem_req dropped, no further bank writes, no writeback.
- Minimum latency for n transfers with zero-wait ack: start@0, first mem_req@1, last ack@n, WB@n+1, done@n+2 (done@n+1 without WB).

Optional Feature:
- Macro: LDM_STM_ABORT_EN.
- Defined:
  - Adds input mem_abort (1 bit) and output aborted (1 bit).
  - mem_abort sampled with mem_req in XFER ends the operation: no bank write for that beat, no WB. Next state is DONE, with aborted=1 alongside done.
  - aborted resets to 0.
- Undefined: neither port exists; every request runs to ack.

Decomposition:
- Shared package cpu_pkg:
  - state enum (IDLE/XFER/WB/DONE)
  - REG_PC = 4'd15, WORD_BYTES = 4, REG_COUNT = 16
  - addressing-mode encoding {P,U} for IA/IB/DA/DB
- Sub-module lowest_set_bit: combinational 16-bit priority encoder, outputs index[3:0] and valid. Used for cur selection; popcount stays inline.

Test Plan:
- STM IA, list=0x000F, base=0x100, W=1, R0..R3=0xA0..0xA3, ack every cycle:
  - 4 stores at 0x100, 0x104, 0x108, 0x10C with data A0..A3
  - WB writes 0x110; done at cycle 6.
- LDM DB, list=0x8003 (R0,R1,R15), base=0x200, W=1, rdata=0x11,0x22,0x33:
  - addresses 0x1F4, 0x1F8, 0x1FC
  - R0=0x11, R1=0x22, R15=0x33; base becomes 0x1F4.
- LDM IA, base_reg=2, list=0x0004, W=1, rdata=0xBEEF:
  - R2=0xBEEF, no WB cycle; done at cycle 2.
- Empty list: done at cycle 1; mem_req and rb_write_en never assert.
- Wait states: ack delayed 3 cycles per beat. mem_req, mem_addr and rb_read_select stay stable until ack; a start pulse during busy is ignored.
- Reset asserted during the 2nd beat of a 4-register LDM:
  - next cycle all outputs 0, state IDLE
  - only R(first) was written; no WB.
